bus_transfer_sequencer: RTL and testbench

- Arbitrates and sequences register-to-register transfers on the shared 8-bit data bus.
- Drives the 2-bit mode inputs of up to NUM_REGS bus registers (MAR and peers) with the mode encoding 00 clear, 01 load, 10 drive, 11 hold/Z.
- Serves NUM_REQ requesters round-robin, one transfer at a time, so exactly one register ever drives the bus.

---
 rtl/bus_transfer_sequencer.sv | 161 ++++++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// rtl/bus_transfer_sequencer.sv - round-robin sequencer for register-to-register transfers on a shared bus
// Build macro SETTLE_CYCLE_EN: when defined, legal moves pass through a SETTLE cycle (source drives alone) before XFER.
// Ports:
//   clock, reset_n    : system clock, synchronous active-low reset
//   req, req_op       : per-requester request (held until done) and op (0 move src->dst, 1 clear dst)
//   req_src, req_dst  : per-requester register indices, flattened, requester 0 in the LSBs
//   grant             : one-hot winner, high for the single ARB cycle
//   done, err         : one-cycle end-of-transaction pulse; err set with done when rejected
//   busy              : high in every state except IDLE
//   register_mode     : mode of register i at [2i+1:2i] (00 clear, 01 load, 10 drive, 11 hold/Z)
module bus_transfer_sequencer #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*IDX_W-1:0] req_src,
    input  logic [NUM_REQ*IDX_W-1:0] req_dst,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     done,
    output logic                     err,
    output logic                     busy,
    output logic [2*NUM_REGS-1:0]    register_mode
);
    localparam int WIN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] M_CLEAR = 2'b00;
    localparam logic [1:0] M_LOAD  = 2'b01;
    localparam logic [1:0] M_DRIVE = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_SETTLE, S_XFER, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [WIN_W-1:0]      rr_q, win_q, win_d, win_pick, scan_idx;
    logic                  found;
    logic                  op_q, op_d;
    logic [IDX_W-1:0]      src_q, src_d, dst_q, dst_d;
    logic [IDX_W-1:0]      src_arr [NUM_REQ];
    logic [IDX_W-1:0]      dst_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    grant_d;
    logic [2*NUM_REGS-1:0] mode_d;
    logic                  done_d, err_d, busy_d;

    function automatic logic is_illegal(input logic op, input logic [IDX_W-1:0] s,
                                        input logic [IDX_W-1:0] d);
        is_illegal = (int'(d) >= NUM_REGS) || (!op && ((int'(s) >= NUM_REGS) || (s == d)));
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            src_arr[i] = req_src[i*IDX_W +: IDX_W];
            dst_arr[i] = req_dst[i*IDX_W +: IDX_W];
        end
    end

    // Scan downward in offset so the smallest offset from the pointer is the last hit and wins.
    always_comb begin
        found    = 1'b0;
        win_pick = rr_q;
        scan_idx = rr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = WIN_W'((int'(rr_q) + i) % NUM_REQ);
            if (req[scan_idx]) begin
                found    = 1'b1;
                win_pick = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_ARB;
                    win_d   = win_pick;
                    op_d    = req_op[win_pick];
                    src_d   = src_arr[win_pick];
                    dst_d   = dst_arr[win_pick];
                end
            end
            S_ARB: begin
                if (is_illegal(op_q, src_q, dst_q)) begin
                    state_d = S_DONE;
                end else if (op_q) begin
                    state_d = S_XFER;
                end else begin
`ifdef SETTLE_CYCLE_EN
                    state_d = S_SETTLE;
`else
                    state_d = S_XFER;
`endif
                end
            end
            S_SETTLE: state_d = S_XFER;
            S_XFER:   state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the cycle of that state.
    always_comb begin
        mode_d = '1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (state_d == S_SETTLE && int'(src_d) == i) begin
                mode_d[2*i +: 2] = M_DRIVE;
            end
            if (state_d == S_XFER) begin
                if (op_d) begin
                    if (int'(dst_d) == i) mode_d[2*i +: 2] = M_CLEAR;
                end else begin
                    if (int'(src_d) == i) mode_d[2*i +: 2] = M_DRIVE;
                    if (int'(dst_d) == i) mode_d[2*i +: 2] = M_LOAD;
                end
            end
        end
        grant_d = '0;
        if (state_d == S_ARB) grant_d[win_d] = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = done_d && is_illegal(op_d, src_d, dst_d);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            rr_q          <= '0;
            win_q         <= '0;
            op_q          <= 1'b0;
            src_q         <= '0;
            dst_q         <= '0;
            grant         <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
            register_mode <= '1;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            op_q          <= op_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            grant         <= grant_d;
            done          <= done_d;
            err           <= err_d;
            busy          <= busy_d;
            register_mode <= mode_d;
            if (state_q == S_DONE) begin
                rr_q <= (win_q == WIN_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb/tb_bus_transfer_sequencer.sv - self-checking bench for bus_transfer_sequencer
module tb_bus_transfer_sequencer;
    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] req_op;
    logic [7:0] req_src;
    logic [7:0] req_dst;
    logic [3:0] grant;
    logic       done;
    logic       err;
    logic       busy;
    logic [7:0] register_mode;

    bus_transfer_sequencer #(.NUM_REQ(4), .NUM_REGS(4), .IDX_W(2)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_op(req_op),
        .req_src(req_src), .req_dst(req_dst), .grant(grant), .done(done),
        .err(err), .busy(busy), .register_mode(register_mode)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         who;
        bit         err;
        bit         chk;
        int         idx;
        logic [7:0] val;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Bus register model: the register in drive mode puts its value on the bus.
    logic [7:0] regv [4];
    logic [7:0] bus;
    logic       pre_we = 1'b0;
    int         pre_idx = 0;
    logic [7:0] pre_val = 8'h00;

    always_comb begin
        bus = 8'h00;
        for (int i = 0; i < 4; i++)
            if (register_mode[2*i +: 2] == 2'b10) bus = regv[i];
    end

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (pre_we && pre_idx == i) regv[i] <= pre_val;
            else if (register_mode[2*i +: 2] == 2'b01) regv[i] <= bus;
            else if (register_mode[2*i +: 2] == 2'b00) regv[i] <= 8'h00;
        end
    end

    int excl_viol = 0;
    always @(negedge clock) begin
        int n10, n00;
        n10 = 0;
        n00 = 0;
        if (reset_n === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                if (register_mode[2*i +: 2] === 2'b10) n10++;
                if (register_mode[2*i +: 2] === 2'b00) n00++;
            end
            if (n10 > 1 || (n10 > 0 && n00 > 0)) excl_viol++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preset(input int idx, input logic [7:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_we  = 1'b1;
        tick();
        pre_we  = 1'b0;
    endtask

    task automatic set_req(input int r, input logic op, input logic [1:0] s, input logic [1:0] d);
        req[r]            = 1'b1;
        req_op[r]         = op;
        req_src[r*2 +: 2] = s;
        req_dst[r*2 +: 2] = d;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 4'b1111; req_op = 4'b1111; req_src = 8'h00; req_dst = 8'hE4;
        tick();
        tick();
        total++; if (register_mode !== 8'hFF) begin bad++; $display("FAIL reset_mode: got %h want ff", register_mode); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
        req = 4'b0000;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_move();
        exp_t e;
        preset(1, 8'hA5);
        preset(3, 8'h00);
        e.who = 2; e.err = 1'b0; e.chk = 1'b1; e.idx = 3; e.val = 8'hA5;
        exp_q.push_back(e);
        set_req(2, 1'b0, 2'd1, 2'd3);
        tick();
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL move_grant: got %b want 0100", grant); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL move_busy: got %b want 1", busy); end
        req = 4'b0000;
`ifdef SETTLE_CYCLE_EN
        tick();
        total++; if (register_mode !== 8'hFB) begin bad++; $display("FAIL move_settle_mode: got %h want fb", register_mode); end
`endif
        tick();
        total++; if (register_mode !== 8'h7B || grant !== 4'b0000) begin bad++; $display("FAIL move_xfer_mode: got %h/%b want 7b/0000", register_mode, grant); end
        tick();
        total++; if (done !== 1'b1 || err !== exp_q[0].err) begin bad++; $display("FAIL move_done: got done=%b err=%b want done=1 err=%b", done, err, exp_q[0].err); end
        total++; if (regv[exp_q[0].idx] !== exp_q[0].val) begin bad++; $display("FAIL move_data: got %h want %h", regv[exp_q[0].idx], exp_q[0].val); end
        total++; if (register_mode !== 8'hFF) begin bad++; $display("FAIL move_done_mode: got %h want ff", register_mode); end
        void'(exp_q.pop_front());
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL move_idle: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int cyc, last_done, grants;
        bit first;
        preset(0, 8'h11);
        preset(1, 8'h22);
        preset(3, 8'h44);
        pulse_reset();
        e.err = 1'b0; e.chk = 1'b1; e.val = 8'h00;
        e.who = 0; e.idx = 0; exp_q.push_back(e);
        e.who = 1; e.idx = 1; exp_q.push_back(e);
        e.who = 3; e.idx = 3; exp_q.push_back(e);
        e.who = 0; e.idx = 0; exp_q.push_back(e);
        set_req(0, 1'b1, 2'd0, 2'd0);
        set_req(1, 1'b1, 2'd0, 2'd1);
        set_req(3, 1'b1, 2'd0, 2'd3);
        cyc = 0; last_done = 0; grants = 0; first = 1'b1;
        while (exp_q.size() != 0 && cyc < 40) begin
            tick();
            cyc++;
            if (grant !== 4'b0000) begin
                total++; if (grant !== 4'(1 << exp_q[0].who)) begin bad++; $display("FAIL rr_grant: got %b want requester %0d", grant, exp_q[0].who); end
                grants++;
                if (grants == 4) req = 4'b0000;
            end
            if (done === 1'b1) begin
                total++; if (err !== exp_q[0].err || regv[exp_q[0].idx] !== exp_q[0].val) begin bad++; $display("FAIL rr_done: got err=%b reg=%h want err=%b reg=%h", err, regv[exp_q[0].idx], exp_q[0].err, exp_q[0].val); end
                if (!first) begin
                    total++; if (cyc - last_done != 4) begin bad++; $display("FAIL rr_period: got %0d want 4", cyc - last_done); end
                end
                first = 1'b0;
                last_done = cyc;
                void'(exp_q.pop_front());
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rr_timeout: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
        tick();
    endtask

    task automatic test_illegal();
        exp_t e;
        int cyc;
        bit nonhold;
        e.who = 0; e.err = 1'b1; e.chk = 1'b0; e.idx = 0; e.val = 8'h00;
        exp_q.push_back(e);
        set_req(0, 1'b0, 2'd2, 2'd2);
        cyc = 0; nonhold = 1'b0;
        while (exp_q.size() != 0 && cyc < 10) begin
            tick();
            cyc++;
            if (register_mode !== 8'hFF) nonhold = 1'b1;
            if (grant !== 4'b0000) begin
                total++; if (grant !== 4'(1 << exp_q[0].who)) begin bad++; $display("FAIL ill_grant: got %b want requester %0d", grant, exp_q[0].who); end
                req = 4'b0000;
            end
            if (done === 1'b1) begin
                total++; if (err !== exp_q[0].err) begin bad++; $display("FAIL ill_err: got %b want %b", err, exp_q[0].err); end
                total++; if (cyc != 2) begin bad++; $display("FAIL ill_latency: got %0d want 2", cyc); end
                void'(exp_q.pop_front());
            end
        end
        total++; if (nonhold) begin bad++; $display("FAIL ill_modes: got non-hold mode want all 11"); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ill_timeout: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
        tick();
    endtask

    task automatic test_clear_abort();
        exp_t e;
        int cyc;
        bit saw_done;
        preset(0, 8'h3C);
        e.who = 1; e.err = 1'b0; e.chk = 1'b1; e.idx = 0; e.val = 8'h00;
        exp_q.push_back(e);
        set_req(1, 1'b1, 2'd0, 2'd0);
        tick();
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL clr_grant: got %b want 0010", grant); end
        req = 4'b0000;
        tick();
        total++; if (register_mode !== 8'hFC) begin bad++; $display("FAIL clr_mode: got %h want fc", register_mode); end
        tick();
        total++; if (done !== 1'b1 || err !== exp_q[0].err || regv[exp_q[0].idx] !== exp_q[0].val) begin bad++; $display("FAIL clr_done: got done=%b err=%b reg=%h want 1 %b %h", done, err, regv[exp_q[0].idx], exp_q[0].err, exp_q[0].val); end
        void'(exp_q.pop_front());
        tick();
        // clear ignores src, so src==dst is still legal
        e.who = 3; e.err = 1'b0; e.chk = 1'b1; e.idx = 2; e.val = 8'h00;
        preset(2, 8'h5A);
        exp_q.push_back(e);
        set_req(3, 1'b1, 2'd2, 2'd2);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 10) begin
            tick();
            cyc++;
            if (grant !== 4'b0000) req = 4'b0000;
            if (done === 1'b1) begin
                total++; if (err !== exp_q[0].err || regv[exp_q[0].idx] !== exp_q[0].val) begin bad++; $display("FAIL clr_same_idx: got err=%b reg=%h want %b %h", err, regv[exp_q[0].idx], exp_q[0].err, exp_q[0].val); end
                void'(exp_q.pop_front());
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL clr_timeout: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
        tick();
        // abort during ARB
        preset(0, 8'h3C);
        set_req(1, 1'b1, 2'd0, 2'd0);
        tick();
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL abort_grant: got %b want 0010", grant); end
        reset_n = 1'b0;
        req = 4'b0000;
        tick();
        total++; if (register_mode !== 8'hFF || busy !== 1'b0 || grant !== 4'b0000) begin bad++; $display("FAIL abort_state: got mode=%h busy=%b grant=%b want ff 0 0000", register_mode, busy, grant); end
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done !== 1'b0) saw_done = 1'b1;
            tick();
        end
        total++; if (saw_done) begin bad++; $display("FAIL abort_done: got done pulse want none"); end
        total++; if (regv[0] !== 8'h3C) begin bad++; $display("FAIL abort_data: got %h want 3c", regv[0]); end
    endtask

    initial begin
        reset_n = 1'b0;
        req = 4'b0000; req_op = 4'b0000; req_src = 8'h00; req_dst = 8'h00;
        test_reset();
        test_move();
        test_round_robin();
        test_illegal();
        test_clear_abort();
        total++; if (excl_viol != 0) begin bad++; $display("FAIL bus_exclusive: got %0d violations want 0", excl_viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
